alu_cmd_driver: RTL and testbench

Initiator for the combinational add_sub_logic ALU: it drives the ALU's op/a/b ports and captures r. It accepts a stream of commands over a valid/ready handshake and keeps a WIDTH-bit accumulator. Each command either loads the accumulator or applies an ALU operation (acc OP operand). When a command is flagged last, the accumulated value goes out on a valid/ready result port. The ALU instance sits beside this block, not inside it.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_ref_model.sv | 26 ++
 rtl/alu_cmd_driver.sv | 108 ++++++++++
 tb/tb_alu_cmd_driver.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU command driver.
// Opcode and FSM state encodings, default width.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_NOTB = 2'd2,
    OP_SGT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden model of the
// add/sub/not-b/set-greater-than ALU.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  // Expected ALU result for the registered issue
  always_comb begin
    r = '0;
    unique case (op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_NOTB: r = ~b;
      OP_SGT:  r = {{(WIDTH-1){1'b0}}, (a > b)};
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: command-stream accumulator driving an
// external ALU. Optional ALU_CHECK_EN adds a sticky err check.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_last,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             err
);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic             last_q;
  logic             cmd_fire;

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Command FSM: load/issue, capture ALU result, publish
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      last_q    <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_load) begin
              acc <= cmd_operand;
              if (cmd_last) begin
                res_data  <= cmd_operand;
                res_valid <= 1'b1;
                state     <= RESULT;
              end
            end else begin
              alu_op <= cmd_op;
              alu_a  <= acc;
              alu_b  <= cmd_operand;
              last_q <= cmd_last;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          acc <= alu_r;
          if (last_q) begin
            res_data  <= alu_r;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            state <= IDLE;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CHECK_EN
  logic [WIDTH-1:0] exp_r;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .r  (exp_r)
  );

  // Sticky flag: ALU disagreed with the model during EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == EXEC && alu_r != exp_r) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized self-checking bench with a
// behavioural ALU beside the DUT and an accumulator model.
module tb_alu_cmd_driver;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_load = 1'b0;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_operand = '0;
  logic         cmd_last = 1'b0;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_r;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         err;
  logic         fault = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .cmd_last    (cmd_last),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_r       (alu_r),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .err         (err)
  );

  function automatic logic [W-1:0] ref_alu(
    input int op, input int a, input int b);
    int v;
    case (op)
      0: v = (a + b) % 65536;
      1: v = (a - b + 65536) % 65536;
      2: v = 65535 - b;
      default: v = (a > b) ? 1 : 0;
    endcase
    return v[W-1:0];
  endfunction

  // stand-in ALU, optionally off by one
  always_comb begin
    alu_r = ref_alu(int'(alu_op), int'(alu_a), int'(alu_b))
          + (fault ? 16'd1 : 16'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic ld, input logic [1:0] op,
                          input logic [W-1:0] v, input logic lst);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_load = ld;
    cmd_op = op;
    cmd_operand = v;
    cmd_last = lst;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout ready=%0b required=1", cmd_ready);
    end else begin
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(input logic [W-1:0] exp,
                            input string nm, input int delay);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!res_valid) begin
      failures++;
      $display("FAIL %s res_timeout valid=0 required=1", nm);
    end else begin
      repeat (delay) tick();
      res_ready = 1'b1;
      if (res_data !== exp) begin
        failures++;
        $display("FAIL %s res_data=%h required=%h",
                 nm, res_data, exp);
      end
      tick();
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, res_valid, err} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b required=100",
               {cmd_ready, res_valid, err});
    end
    checks++;
    if ({res_data, alu_a, alu_b, alu_op} !== '0) begin
      failures++;
      $display("FAIL reset_regs res=%h a=%h b=%h op=%0d required=0",
               res_data, alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_directed();
    send_cmd(1'b1, 2'd0, 16'd2, 1'b0);
    send_cmd(1'b0, 2'd0, 16'd3, 1'b1);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL exec_ready got=%b required=0", cmd_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd5) begin
      failures++;
      $display("FAIL add_latency valid=%b data=%h required=1/0005",
               res_valid, res_data);
    end
    get_result(16'd5, "add", 0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean got=%b required=0", err);
    end
    send_cmd(1'b1, 2'd0, 16'd100, 1'b0);
    send_cmd(1'b0, 2'd1, 16'd200, 1'b1);
    get_result(16'hff9c, "sub_wrap", 0);
    send_cmd(1'b1, 2'd0, 16'd11, 1'b0);
    send_cmd(1'b0, 2'd2, 16'd7, 1'b1);
    get_result(16'hfff8, "notb", 0);
    send_cmd(1'b1, 2'd0, 16'd3, 1'b0);
    send_cmd(1'b0, 2'd3, 16'd10, 1'b1);
    get_result(16'd0, "sgt_false", 0);
    send_cmd(1'b1, 2'd0, 16'd10, 1'b0);
    send_cmd(1'b0, 2'd3, 16'd3, 1'b1);
    get_result(16'd1, "sgt_true", 0);
    send_cmd(1'b1, 2'd0, 16'd10, 1'b0);
    send_cmd(1'b0, 2'd3, 16'd10, 1'b1);
    get_result(16'd0, "sgt_equal", 0);
    send_cmd(1'b1, 2'd0, 16'h1234, 1'b1);
    get_result(16'h1234, "load_last", 0);
  endtask

  task automatic test_backpressure();
    logic ok;
    ok = 1'b1;
    send_cmd(1'b1, 2'd0, 16'd2, 1'b0);
    send_cmd(1'b0, 2'd0, 16'd3, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 16'd5
          || cmd_ready !== 1'b0)
        ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_stable valid=%b data=%h ready=%b required=1/0005/0",
               res_valid, res_data, cmd_ready);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL release ready=%b valid=%b required=1/0",
               cmd_ready, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [4];
    logic [1:0]   ops [4];
    logic [6:0]   pat;
    int           k;
    logic         r;
    vals = '{16'd10, 16'd5, 16'd3, 16'd1};
    ops = '{2'd0, 2'd0, 2'd1, 2'd0};
    k = 0;
    pat = '0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (k < 4) begin
        cmd_load = (k == 0);
        cmd_op = ops[k];
        cmd_operand = vals[k];
        cmd_last = (k == 3);
      end else begin
        cmd_valid = 1'b0;
      end
      r = cmd_ready;
      pat[6-c] = r;
      tick();
      if (r && k < 4) k++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (pat !== 7'b1101010) begin
      failures++;
      $display("FAIL chain_ready got=%b required=1101010", pat);
    end
    get_result(16'd13, "chain", 2);
  endtask

  task automatic test_random();
    int acc;
    int nops;
    int op;
    int v;
    for (int s = 0; s < 40; s++) begin
      acc = int'($urandom_range(0, 65535));
      nops = int'($urandom_range(0, 4));
      send_cmd(1'b1, 2'd0, acc[W-1:0], nops == 0);
      for (int j = 0; j < nops; j++) begin
        op = int'($urandom_range(0, 3));
        v = ($urandom_range(0, 3) == 0)
          ? acc : int'($urandom_range(0, 65535));
        acc = int'(ref_alu(op, acc, v));
        repeat ($urandom_range(0, 2)) tick();
        send_cmd(1'b0, op[1:0], v[W-1:0], j == nops - 1);
      end
      get_result(acc[W-1:0], "random", int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    send_cmd(1'b1, 2'd0, 16'd2, 1'b0);
    send_cmd(1'b0, 2'd0, 16'd3, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, res_valid} !== 2'b10 || res_data !== '0
        || alu_a !== '0 || alu_b !== '0) begin
      failures++;
      $display("FAIL mid_reset ready=%b valid=%b res=%h a=%h b=%h required=1/0/0/0/0",
               cmd_ready, res_valid, res_data, alu_a, alu_b);
    end
    for (int i = 0; i < 4; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_reset_result got=1 required=0");
    end
    send_cmd(1'b0, 2'd0, 16'd7, 1'b1);
    get_result(16'd7, "acc_cleared", 0);
  endtask

`ifdef ALU_CHECK_EN
  task automatic test_err();
    fault = 1'b1;
    send_cmd(1'b1, 2'd0, 16'd2, 1'b0);
    send_cmd(1'b0, 2'd0, 16'd3, 1'b1);
    get_result(16'd6, "faulty_alu", 0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b required=1", err);
    end
    fault = 1'b0;
    send_cmd(1'b1, 2'd0, 16'd4, 1'b0);
    send_cmd(1'b0, 2'd0, 16'd1, 1'b1);
    get_result(16'd5, "after_fault", 0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b required=1", err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b required=0", err);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef ALU_CHECK_EN
    test_err();
`endif
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL final_err got=%b required=0", err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
